// File: rtl/icache_resp.sv
// ---------------------------------------------------------------------------
// icache_resp
// Instruction-side fetch responder. Fetch requests (ice, if_iaddr) are answered
// combinationally from a direct-mapped cache of 2^INDEX_W lines x 4 words.
// A miss refills the whole line, word 0 to 3, over an SRAM-like bus that
// allows one outstanding request at a time.
//
// Ports
//   cpu_clk_50M  in   clock, rising edge
//   rst          in   synchronous active-high reset
//   ice          in   fetch request valid (held until if_hit)
//   if_iaddr     in   fetch byte address, bits [1:0] ignored
//   flush        in   one-cycle pulse, invalidates the whole cache
//   if_rdata     out  fetched instruction, 0 when if_hit=0
//   if_hit       out  if_rdata valid this cycle (combinational)
//   mem_req      out  memory read request (registered)
//   mem_addr     out  word-aligned memory read address (registered)
//   mem_addr_ok  in   request accepted this cycle
//   mem_data_ok  in   read data returned this cycle
//   mem_rdata    in   read data
//
// Build option: ICACHE_BYPASS_EN -- when defined, fetches with
// if_iaddr[31:28]=4'h1 are read as a single uncached word and never allocate.
// ---------------------------------------------------------------------------
module icache_resp #(
   parameter int INDEX_W = 7
) (
   input  logic        cpu_clk_50M,
   input  logic        rst,
   input  logic        ice,
   input  logic [31:0] if_iaddr,
   input  logic        flush,
   output logic [31:0] if_rdata,
   output logic        if_hit,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int TAG_W = 28 - INDEX_W;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   state_t             state, state_nxt;
   logic [LINES-1:0]   valid;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [31:0]        data_mem [LINES*4];
   logic [1:0]         cnt;
   logic [TAG_W-1:0]   line_tag;
   logic [INDEX_W-1:0] line_idx;
   logic               flush_pend;

   logic [1:0]         req_off;
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic               flush_now;
   logic               cache_hit;
   logic               last_word;
   logic               fill_en;
   logic [31:0]        start_addr;
   logic               unused_ok;

   assign req_off   = if_iaddr[3:2];
   assign req_idx   = if_iaddr[INDEX_W+3:4];
   assign req_tag   = if_iaddr[31:INDEX_W+4];
   assign unused_ok = &{1'b0, if_iaddr[1:0]};

   // A flush raised during a refill is held and takes effect in the first
   // IDLE cycle, so the line that was just completed is invalidated as well.
   assign flush_now = (state == IDLE) && (flush || flush_pend);

`ifdef ICACHE_BYPASS_EN
   logic        req_byp;
   logic        line_byp;
   logic        byp_vld_p1;
   logic [31:0] byp_rdata_p1;

   assign req_byp    = (if_iaddr[31:28] == 4'h1);
   assign cache_hit  = ice && !req_byp && valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign last_word  = line_byp || (cnt == 2'd3);
   assign fill_en    = (state == WAIT) && mem_data_ok && !line_byp && !rst;
   assign start_addr = req_byp ? {if_iaddr[31:2], 2'b00} : {if_iaddr[31:4], 4'b0000};

   // ---- bypass word register: returned word is presented for one IDLE cycle
   always_ff @(posedge cpu_clk_50M) begin
      if (rst) begin
         line_byp   <= 1'b0;
         byp_vld_p1 <= 1'b0;
      end else begin
         byp_vld_p1 <= (state == WAIT) && mem_data_ok && line_byp;
         if ((state == IDLE) && (state_nxt == REQ)) line_byp <= req_byp;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if ((state == WAIT) && mem_data_ok && line_byp) byp_rdata_p1 <= mem_rdata;
   end
`else
   assign cache_hit  = ice && valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign last_word  = (cnt == 2'd3);
   assign fill_en    = (state == WAIT) && mem_data_ok && !rst;
   assign start_addr = {if_iaddr[31:4], 4'b0000};
`endif

   // ---- lookup / next state
   always_comb begin
      state_nxt = state;
      if_hit    = 1'b0;
      if_rdata  = 32'd0;
      case (state)
         IDLE: begin
            if (!flush_now) begin
`ifdef ICACHE_BYPASS_EN
               if (byp_vld_p1) begin
                  if_hit   = 1'b1;
                  if_rdata = byp_rdata_p1;
               end else
`endif
               if (cache_hit) begin
                  if_hit   = 1'b1;
                  if_rdata = data_mem[{req_idx, req_off}];
               end
            end
            if (ice && !if_hit) state_nxt = REQ;
         end
         REQ:     if (mem_addr_ok) state_nxt = WAIT;
         WAIT:    if (mem_data_ok) state_nxt = last_word ? IDLE : REQ;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- control state and memory request
   always_ff @(posedge cpu_clk_50M) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         mem_req    <= 1'b0;
         mem_addr   <= 32'd0;
         flush_pend <= 1'b0;
         valid      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               flush_pend <= 1'b0;
               if (flush_now) valid <= '0;
               if (state_nxt == REQ) begin
                  cnt      <= 2'd0;
                  mem_req  <= 1'b1;
                  mem_addr <= start_addr;
               end
            end
            REQ: begin
               if (flush) flush_pend <= 1'b1;
               if (mem_addr_ok) mem_req <= 1'b0;
            end
            WAIT: begin
               if (flush) flush_pend <= 1'b1;
               if (mem_data_ok) begin
                  if (last_word) begin
                     cnt <= 2'd0;
                     if (fill_en) valid[line_idx] <= 1'b1;
                  end else begin
                     cnt      <= cnt + 2'd1;
                     mem_req  <= 1'b1;
                     mem_addr <= {line_tag, line_idx, cnt + 2'd1, 2'b00};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ---- refill line address, captured at miss time so the refill is
   //      independent of whatever the CPU drives afterwards
   always_ff @(posedge cpu_clk_50M) begin
      if ((state == IDLE) && (state_nxt == REQ)) begin
         line_tag <= req_tag;
         line_idx <= req_idx;
      end
   end

   // ---- array write
   always_ff @(posedge cpu_clk_50M) begin
      if (fill_en) begin
         data_mem[{line_idx, cnt}] <= mem_rdata;
         if (cnt == 2'd3) tag_mem[line_idx] <= line_tag;
      end
   end

endmodule

// File: tb/tb_icache_resp.sv
module tb_icache_resp;

   logic        cpu_clk_50M;
   logic        rst;
   logic        ice;
   logic [31:0] if_iaddr;
   logic        flush;
   logic [31:0] if_rdata;
   logic        if_hit;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   int addr_stall = 0;
   int data_stall = 0;

   icache_resp #(.INDEX_W(7)) dut (
      .cpu_clk_50M (cpu_clk_50M),
      .rst         (rst),
      .ice         (ice),
      .if_iaddr    (if_iaddr),
      .flush       (flush),
      .if_rdata    (if_rdata),
      .if_hit      (if_hit),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_addr_ok (mem_addr_ok),
      .mem_data_ok (mem_data_ok),
      .mem_rdata   (mem_rdata)
   );

   initial begin
      cpu_clk_50M = 1'b0;
      forever #5 cpu_clk_50M = ~cpu_clk_50M;
   end

   function automatic logic [31:0] memval(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: grants requests after addr_stall cycles, returns data
   // data_stall cycles after the cycle following acceptance. Accepted
   // addresses are checked against the scoreboard queue.
   initial begin : mem_model
      bit          pend;
      logic [31:0] pend_addr;
      int          a_wait;
      int          d_wait;
      logic [31:0] exp_a;
      pend = 0; pend_addr = 0; a_wait = 0; d_wait = 0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
      forever begin
         @(posedge cpu_clk_50M);
         #2;
         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b0;
         if (rst === 1'b1) begin
            pend   = 0;
            a_wait = 0;
         end else begin
            if (pend) begin
               if (d_wait == 0) begin
                  mem_data_ok = 1'b1;
                  mem_rdata   = memval(pend_addr);
                  pend        = 0;
               end else begin
                  d_wait--;
               end
            end
            if (mem_req === 1'b1) begin
               if (a_wait >= addr_stall) begin
                  mem_addr_ok = 1'b1;
                  pend        = 1;
                  pend_addr   = mem_addr;
                  d_wait      = data_stall;
                  a_wait      = 0;
                  if (exp_addr_q.size() == 0) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL mem_addr: got unexpected request %h expected none", mem_addr);
                  end else begin
                     exp_a = exp_addr_q.pop_front();
                     chk("mem_addr", mem_addr, exp_a);
                  end
               end else begin
                  a_wait++;
               end
            end
         end
      end
   end

   // Drive one fetch and hold it until if_hit; expected data and the expected
   // memory request sequence are queued first, then checked as they appear.
   task automatic fetch(input logic [31:0] a, input int nref, input int exp_lat,
                        input int flush_at, input bit byp);
      int          lat;
      bit          done;
      logic [31:0] exp_d;
      logic [1:0]  wi;
      @(negedge cpu_clk_50M);
      ice      = 1'b1;
      if_iaddr = a;
      flush    = (flush_at == 0);
      exp_data_q.push_back(memval({a[31:2], 2'b00}));
      for (int r = 0; r < nref; r++) begin
         if (byp) exp_addr_q.push_back({a[31:2], 2'b00});
         else begin
            for (int w = 0; w < 4; w++) begin
               wi = w[1:0];
               exp_addr_q.push_back({a[31:4], wi, 2'b00});
            end
         end
      end
      lat  = 0;
      done = 0;
      while (!done) begin
         #1;
         if (if_hit === 1'b1) begin
            exp_d = exp_data_q.pop_front();
            chk($sformatf("if_rdata@%h", a), if_rdata, exp_d);
            done = 1;
         end else if (lat >= exp_lat + 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL hit_timeout@%h: got no if_hit after %0d cycles expected at %0d", a, lat, exp_lat);
            exp_d = exp_data_q.pop_front();
            done  = 1;
         end else begin
            if (lat == 0) chk("if_rdata_zero_on_miss", if_rdata, 32'd0);
            @(negedge cpu_clk_50M);
            lat++;
            flush = (lat == flush_at);
         end
      end
      flush = 1'b0;
      chk($sformatf("latency@%h", a), lat, exp_lat);
      chk($sformatf("mem_reqs_drained@%h", a), exp_addr_q.size(), 0);
      exp_addr_q.delete();
   endtask

   typedef struct packed {
      logic [31:0] addr;
      logic        miss;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{addr: 32'h0000_0100, miss: 1'b1};
      vecs[1]  = '{addr: 32'h0000_0104, miss: 1'b0};
      vecs[2]  = '{addr: 32'h0000_0108, miss: 1'b0};
      vecs[3]  = '{addr: 32'h0000_010C, miss: 1'b0};
      vecs[4]  = '{addr: 32'h0000_0900, miss: 1'b1};
      vecs[5]  = '{addr: 32'h0000_0100, miss: 1'b1};
      vecs[6]  = '{addr: 32'h0000_020C, miss: 1'b1};
      vecs[7]  = '{addr: 32'h0000_0200, miss: 1'b0};
      vecs[8]  = '{addr: 32'h0000_07F8, miss: 1'b1};
      vecs[9]  = '{addr: 32'hFFFF_FFF0, miss: 1'b1};
      vecs[10] = '{addr: 32'hFFFF_FFFC, miss: 1'b0};
      vecs[11] = '{addr: 32'h0000_07F0, miss: 1'b1};
      vecs[12] = '{addr: 32'h0000_0104, miss: 1'b0};

      rst = 1'b1; ice = 1'b0; if_iaddr = 32'd0; flush = 1'b0;
      repeat (3) @(negedge cpu_clk_50M);
      rst = 1'b0;
      #1;
      chk("reset_if_hit",   if_hit,   32'd0);
      chk("reset_if_rdata", if_rdata, 32'd0);
      chk("reset_mem_req",  mem_req,  32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);

      for (int i = 0; i < NV; i++)
         fetch(vecs[i].addr, vecs[i].miss ? 1 : 0, vecs[i].miss ? 9 : 0, -1, 1'b0);

      // stalls add cycles one-for-one: +1 per grant, +2 per data word
      addr_stall = 1;
      data_stall = 2;
      fetch(32'h0000_0300, 1, 21, -1, 1'b0);
      addr_stall = 0;
      data_stall = 0;

      // reset while waiting for the first refill word
      exp_addr_q.push_back(32'h0000_0500);
      @(negedge cpu_clk_50M);
      ice = 1'b1; if_iaddr = 32'h0000_0500;
      @(negedge cpu_clk_50M);
      #1 chk("mem_req_in_req", mem_req, 32'd1);
      @(negedge cpu_clk_50M);
      rst = 1'b1; ice = 1'b0;
      @(posedge cpu_clk_50M);
      #1;
      chk("rst_wait_mem_req",  mem_req,  32'd0);
      chk("rst_wait_mem_addr", mem_addr, 32'd0);
      chk("rst_wait_if_hit",   if_hit,   32'd0);
      @(negedge cpu_clk_50M);
      rst = 1'b0;
      chk("rst_wait_reqs_drained", exp_addr_q.size(), 0);
      exp_addr_q.delete();
      fetch(32'h0000_0104, 1, 9, -1, 1'b0);

      // flush in third word's WAIT: refill completes, line is then dropped,
      // held fetch misses again and refills a second time
      fetch(32'h0000_0400, 2, 18, 6, 1'b0);

      // flush in IDLE on a cached line: no hit that cycle, all lines cleared
      fetch(32'h0000_0104, 1, 9, -1, 1'b0);
      fetch(32'h0000_0404, 1, 9, 0, 1'b0);
      fetch(32'h0000_0408, 0, 0, -1, 1'b0);
      fetch(32'h0000_0100, 1, 9, -1, 1'b0);

`ifdef ICACHE_BYPASS_EN
      fetch(32'h1000_0040, 1, 3, -1, 1'b1);
      fetch(32'h1000_0040, 1, 3, -1, 1'b1);
`endif

      @(negedge cpu_clk_50M);
      ice = 1'b0;
      repeat (2) @(negedge cpu_clk_50M);
      chk("no_stray_mem_req", mem_req, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_resp.md
# icache_resp

Instruction-side responder for the CPU fetch path. It answers fetch requests (ice, if_iaddr) with if_rdata/if_hit from a direct-mapped instruction cache of 4-word lines. On a miss it refills the line from the instruction memory over an SRAM-like request/response bus. It sits between the fetch-address arbiter (which consumes if_hit as its data-ok) and the instruction memory port.

## Interface
- INDEX_W, 7, index width; the cache holds 2^INDEX_W lines of 4 words (default 2 KiB)

- cpu_clk_50M  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ice  in  1  fetch request valid; the CPU holds ice and if_iaddr stable until if_hit
- if_iaddr  in  32  fetch byte address; bits [1:0] ignored
- flush  in  1  one-cycle pulse that invalidates the whole cache
- if_rdata  out  32  fetched instruction; forced to 0 when if_hit=0
- if_hit  out  1  if_rdata valid this cycle (combinational)
- mem_req  out  1  memory read request (registered)
- mem_addr  out  32  word-aligned memory read address (registered)
- mem_addr_ok  in  1  request accepted in this cycle while mem_req=1
- mem_data_ok  in  1  read data returned in this cycle
- mem_rdata  in  32  read data, valid with mem_data_ok

## Operation
- Address split: offset = if_iaddr[3:2]; index = if_iaddr[INDEX_W+3:4]; tag = if_iaddr[31:INDEX_W+4].
- Arrays: the valid bits are registers. The tag and data arrays use asynchronous reads and synchronous writes.
- States: IDLE, REQ, WAIT. A 2-bit word counter cnt tracks the refill.
- IDLE:
  - if_hit = ice & valid[index] & (tag match).
  - On ice & !hit: latch the line address and cnt=0, then go to REQ.
- REQ:
  - mem_req=1 and mem_addr={line tag, index, cnt, 2'b00}.
  - When mem_addr_ok=1, drop mem_req and go to WAIT.
- WAIT:
  - When mem_data_ok=1, write mem_rdata into data[index][cnt].
  - If cnt≠3: increment cnt and go to REQ.
  - If cnt=3: write the tag, set valid[index] and go to IDLE.
- There is one outstanding memory request at a time. mem_data_ok is ignored outside WAIT.
- Once a refill starts it always completes. This holds even if ice drops or if_iaddr changes.
- if_hit is forced to 0 in REQ and WAIT.
- flush:
  - In IDLE: all valid bits clear at the edge, and if_hit=0 in the flush cycle.
  - In REQ or WAIT: flush is latched and applied on the cycle the FSM returns to IDLE. The just-refilled line is cleared too, and if_hit=0 in that cycle.
- Reset:
  - All valid bits are cleared and the FSM goes to IDLE.
  - Reset values: mem_req=0, mem_addr=0, if_hit=0, if_rdata=0, cnt=0, pending flush=0.
  - Reset during a refill abandons it. The memory side shares rst.

## Timing
- Hit: if_hit and if_rdata are valid in the same cycle as the request (zero added latency).
- Miss detected at cycle t:
  - mem_req rises at t+1.
  - With mem_addr_ok at the same cycle as the request and mem_data_ok one cycle later, the words return at t+2, t+4, t+6 and t+8.
  - if_hit=1 at t+9 (minimum miss penalty: 9 cycles).
- Any addr_ok or data_ok stall adds cycles one-for-one.
- Refill order is always word 0→3 of the line; there is no critical-word-first.

## Configuration
- ICACHE_BYPASS_EN defined: fetches with if_iaddr[31:28]=4'h1 are uncached.
  - FSM path: IDLE → REQ (single word, mem_addr={if_iaddr[31:2],2'b00}) → WAIT.
  - On mem_data_ok, mem_rdata is registered and the FSM enters IDLE.
  - In the first IDLE cycle after that, if_hit=1 for exactly one cycle with the registered word.
  - The arrays are never written.
- ICACHE_BYPASS_EN undefined: all addresses are cached; there is no bypass logic.

## Test plan
- Reset, then ice=1, if_iaddr=0x0000_0100 -> if_hit=0; mem_req=1 with mem_addr 0x100, 0x104, 0x108, 0x10C in order; if_hit=1 9 cycles after the request (zero-stall memory) with if_rdata = the word returned for 0x100.
- After that refill, fetch 0x0000_0104, 0x108 and 0x10C -> if_hit=1 in the request cycle, returning the refilled words, with no mem_req.
- Fetch 0x0000_0900 with INDEX_W=7 (same index as 0x100, different tag) -> miss and refill; a re-fetch of 0x100 then misses again.
- Pulse flush during the third word's WAIT of a refill -> refill completes; valid is cleared on return to IDLE; the next fetch of the same address misses.
- Assert rst while in WAIT -> next cycle mem_req=0 and the FSM is in IDLE; a fetch of a previously cached address misses.
- With ICACHE_BYPASS_EN defined, fetch 0x1000_0040 twice -> each fetch issues a single mem_req to 0x1000_0040 and gets a one-cycle if_hit; no line is allocated.
